// File: rtl/sum_display.sv
// Captures an 8-bit adder result, converts it to three BCD digits with a
// sequential double-dabble engine, and scans it onto a 4-digit common-anode display.
module sum_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sum,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_OFF   = 7'b1111111;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  bin_q;
  logic [11:0] scratch_q;
  logic [3:0]  cnt_q;
  logic [11:0] scratch_adj;
  logic [19:0] shifted;
  logic        done_q;
  logic [3:0]  hund_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;

  logic [15:0] scan_cnt_q;
  logic [1:0]  slot_q;
  logic [3:0]  digit;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_q == 4'd1) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Correct each BCD nibble before the shift so it carries properly into the next decade.
  always_comb begin
    scratch_adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    shifted     = {scratch_adj, bin_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin_q     <= sum;
            scratch_q <= '0;
            cnt_q     <= 4'd8;
          end
        end
        SHIFT: begin
          scratch_q <= shifted[19:8];
          bin_q     <= shifted[7:0];
          cnt_q     <= cnt_q - 4'd1;
        end
        DONE: begin
          hund_q <= scratch_q[11:8];
          tens_q <= scratch_q[7:4];
          ones_q <= scratch_q[3:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign bcd_hund = hund_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      slot_q     <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      slot_q     <= slot_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 16'd1;
    end
  end

  // Blanked leading digits keep their anode enabled; only slot 3 is fully dark.
  always_comb begin
    an    = 4'b1111;
    digit = ones_q;
    blank = 1'b0;
    case (slot_q)
      2'd0: begin
        an    = 4'b1110;
        digit = ones_q;
      end
      2'd1: begin
        an    = 4'b1101;
        digit = tens_q;
        blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        an    = 4'b1011;
        digit = hund_q;
        blank = (hund_q == 4'd0);
      end
      default: blank = 1'b1;
    endcase
    seg = blank ? SEG_OFF : seg_code(digit);
  end

  assign dp = 1'b1;

endmodule
